// File: rtl/spi_audio_pkg.sv
// Shared types and constants for the SPI audio capture front end.
package spi_audio_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'h0,
        ST_CAPTURE   = 4'h1,
        ST_PROCESS   = 4'h2,
        ST_TX_WAIT   = 4'h3,
        ST_SEND      = 4'h4,
        ST_ECHO_WAIT = 4'h5,
        ST_ECHO      = 4'h6,
        ST_CHECK     = 4'h7,
        ST_DONE      = 4'h8,
        ST_ERR       = 4'h9
    } state_t;

    // SPI mode 0: idle-low clock, sample on the leading edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Index width that never collapses to zero bits.
    function automatic int clog2_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_word_engine.sv
// Oversampled SPI slave word engine: pin synchronisers, edge detect,
// shift-in/shift-out registers and the bit counter.
module spi_word_engine
    import spi_audio_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              ss,
    input  logic              sdi,
    input  logic              tx_load,
    input  logic              tx_shift_en,
    input  logic [WORD_W-1:0] tx_word,
    output logic              tx_bit,
    output logic              word_done,
    output logic              ss_rise,
    output logic              ss_fall,
    output logic [WORD_W-1:0] rx_word
);

    localparam int NPIN    = 3;
    localparam int PIN_SCK = 0;
    localparam int PIN_SS  = 1;
    localparam int PIN_SDI = 2;
    localparam int CNT_W   = clog2_w(WORD_W);

    logic [NPIN-1:0] pins;
    logic [NPIN-1:0] sync_w;

    assign pins = {sdi, ss, sck};

    // Synchronisers run through reset so a frame held across reset does not
    // look like a fresh ss edge once reset releases.
    for (genvar gi = 0; gi < NPIN; gi++) begin : g_sync
        logic meta_q;
        logic sync_q;
        always_ff @(posedge clk) begin
            meta_q <= pins[gi];
            sync_q <= meta_q;
        end
        assign sync_w[gi] = sync_q;
    end

    logic sck_act;
    logic sck_prev_q;
    logic ss_prev_q;
    logic sck_lead;
    logic sck_trail;
    logic sample_edge;
    logic shift_edge;

    assign sck_act = sync_w[PIN_SCK] ^ SPI_CPOL;

    always_ff @(posedge clk) begin
        sck_prev_q <= sck_act;
        ss_prev_q  <= sync_w[PIN_SS];
    end

    assign sck_lead    = sck_act & ~sck_prev_q;
    assign sck_trail   = ~sck_act & sck_prev_q;
    assign sample_edge = SPI_CPHA ? sck_trail : sck_lead;
    assign shift_edge  = SPI_CPHA ? sck_lead : sck_trail;
    assign ss_rise     = sync_w[PIN_SS] & ~ss_prev_q;
    assign ss_fall     = ~sync_w[PIN_SS] & ss_prev_q;

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] rx_q, rx_d;
    logic [WORD_W-1:0] tx_q, tx_d;
    logic              done_q, done_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        if (ss_fall) begin
            bit_cnt_d = '0;
        end else if (sample_edge && sync_w[PIN_SS]) begin
            rx_d = {rx_q[WORD_W-2:0], sync_w[PIN_SDI]};
            if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
                bit_cnt_d = '0;
                done_d    = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
        if (tx_load) begin
            tx_d = tx_word;
        end else if (tx_shift_en && shift_edge && sync_w[PIN_SS]) begin
            tx_d = {tx_q[WORD_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign tx_bit    = tx_q[WORD_W-1];
    assign word_done = done_q;
    assign rx_word   = rx_q;

endmodule

// File: rtl/spi_audio_capture.sv
// SPI audio capture top: sample buffer, matcher handshake and result
// transmit/echo-verify loop with bounded retries.
module spi_audio_capture
    import spi_audio_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int SAMPLE_W  = 10,
    parameter int DEPTH     = 1000,
    parameter int MAX_RETRY = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sck,
    input  logic                          ss,
    input  logic                          sdi,
    output logic                          sdo,
    input  logic [WORD_W-1:0]             result,
    input  logic                          result_valid,
    input  logic [clog2_w(DEPTH)-1:0]     rd_addr,
    output logic [SAMPLE_W-1:0]           rd_data,
    output logic [clog2_w(DEPTH+1)-1:0]   sample_count,
    output logic                          input_ready,
    output logic                          transmit_ready,
    output logic                          data_confirmed,
    output logic                          error,
    output logic [3:0]                    state_o
);

    localparam int AW = clog2_w(DEPTH);
    localparam int CW = clog2_w(DEPTH + 1);
    localparam int RW = clog2_w(MAX_RETRY + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [WORD_W-1:0] result_q, result_d;
    logic [WORD_W-1:0] echo_q, echo_d;
    logic              sent_full_q, sent_full_d;
    logic              input_ready_q, input_ready_d;
    logic              transmit_ready_q, transmit_ready_d;
    logic              confirmed_q, confirmed_d;
    logic              error_q, error_d;
    logic              wr_en;

    logic              tx_bit;
    logic              word_done;
    logic              ss_rise;
    logic              ss_fall;
    logic [WORD_W-1:0] rx_word;

    spi_word_engine #(
        .WORD_W(WORD_W)
    ) u_engine (
        .clk         (clk),
        .reset       (reset),
        .sck         (sck),
        .ss          (ss),
        .sdi         (sdi),
        .tx_load     (state_q == ST_TX_WAIT),
        .tx_shift_en (state_q == ST_SEND),
        .tx_word     (result_q),
        .tx_bit      (tx_bit),
        .word_done   (word_done),
        .ss_rise     (ss_rise),
        .ss_fall     (ss_fall),
        .rx_word     (rx_word)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        retry_d     = retry_q;
        result_d    = result_q;
        echo_d      = echo_q;
        sent_full_d = sent_full_q;
        wr_en       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (ss_rise) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (word_done) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(DEPTH - 1)) state_d = ST_PROCESS;
                end
            end
            ST_PROCESS: begin
                if (result_valid) begin
                    result_d = result;
                    retry_d  = '0;
                    state_d  = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                sent_full_d = 1'b0;
                if (ss_rise) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (word_done) sent_full_d = 1'b1;
                // An early ss drop just re-arms the same transmission.
                if (ss_fall) state_d = sent_full_q ? ST_ECHO_WAIT : ST_TX_WAIT;
            end
            ST_ECHO_WAIT: begin
                if (ss_rise) state_d = ST_ECHO;
            end
            ST_ECHO: begin
                if (word_done) begin
                    echo_d  = rx_word;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (echo_q == result_q) begin
                    state_d = ST_DONE;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_TX_WAIT;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (ss_rise) begin
                    count_d = '0;
                    state_d = ST_CAPTURE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        input_ready_d    = (state_d == ST_PROCESS);
        transmit_ready_d = (state_d == ST_TX_WAIT);
        confirmed_d      = (state_d == ST_DONE);
        error_d          = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            count_q          <= '0;
            retry_q          <= '0;
            result_q         <= '0;
            echo_q           <= '0;
            sent_full_q      <= 1'b0;
            input_ready_q    <= 1'b0;
            transmit_ready_q <= 1'b0;
            confirmed_q      <= 1'b0;
            error_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            retry_q          <= retry_d;
            result_q         <= result_d;
            echo_q           <= echo_d;
            sent_full_q      <= sent_full_d;
            input_ready_q    <= input_ready_d;
            transmit_ready_q <= transmit_ready_d;
            confirmed_q      <= confirmed_d;
            error_q          <= error_d;
        end
    end

    // Buffer contents survive reset; sample_count alone marks validity.
    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [SAMPLE_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (reset && wr_en) mem[count_q[AW-1:0]] <= rx_word[SAMPLE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) rd_data_q <= '0;
        else        rd_data_q <= mem[rd_addr];
    end

    assign sdo            = (state_q == ST_SEND) & tx_bit;
    assign rd_data        = rd_data_q;
    assign sample_count   = count_q;
    assign input_ready    = input_ready_q;
    assign transmit_ready = transmit_ready_q;
    assign data_confirmed = confirmed_q;
    assign error          = error_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_spi_audio_capture.sv
// Self-checking bench: SPI master model with a scoreboard of expected samples
// and expected transmitted words.
module tb_spi_audio_capture;

    localparam int WORD_W    = 32;
    localparam int SAMPLE_W  = 10;
    localparam int DEPTH     = 4;
    localparam int MAX_RETRY = 2;
    localparam int HALF      = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              sck = 1'b0;
    logic              ss = 1'b0;
    logic              sdi = 1'b0;
    logic              sdo;
    logic [WORD_W-1:0] result = '0;
    logic              result_valid = 1'b0;
    logic [1:0]        rd_addr = '0;
    logic [SAMPLE_W-1:0] rd_data;
    logic [2:0]        sample_count;
    logic              input_ready;
    logic              transmit_ready;
    logic              data_confirmed;
    logic              error;
    logic [3:0]        state_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [SAMPLE_W-1:0] sample_q [$];
    logic [WORD_W-1:0]   tx_q [$];
    logic [WORD_W-1:0]   latched_exp = '0;
    logic [WORD_W-1:0]   test_words [4] = '{32'h3FF, 32'hABC, 32'h001, 32'h200};

    spi_audio_capture #(
        .WORD_W    (WORD_W),
        .SAMPLE_W  (SAMPLE_W),
        .DEPTH     (DEPTH),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sck            (sck),
        .ss             (ss),
        .sdi            (sdi),
        .sdo            (sdo),
        .result         (result),
        .result_valid   (result_valid),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .sample_count   (sample_count),
        .input_ready    (input_ready),
        .transmit_ready (transmit_ready),
        .data_confirmed (data_confirmed),
        .error          (error),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ss_up();
        ss = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic ss_down();
        wait_clk(HALF);
        ss = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic xfer(input logic [31:0] w, input int nbits, output logic [31:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            sdi = w[31-i];
            wait_clk(HALF);
            rx  = {rx[30:0], sdo};
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
        sdi = 1'b0;
    endtask

    task automatic send_sample(input logic [31:0] w);
        logic [31:0] unused_rx;
        xfer(w, 32, unused_rx);
        sample_q.push_back(w[SAMPLE_W-1:0]);
    endtask

    task automatic check_buffer(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 2'(a);
            wait_clk(1);
            check_eq($sformatf("%s_rd%0d", tag, a), 32'(rd_data), 32'(sample_q.pop_front()));
        end
    endtask

    task automatic pulse_result(input logic [31:0] v);
        result       = v;
        result_valid = 1'b1;
        wait_clk(1);
        result_valid = 1'b0;
    endtask

    task automatic transmit(input logic [31:0] echo_w);
        logic [31:0] got;
        logic [31:0] unused_rx;
        tx_q.push_back(latched_exp);
        ss_up();
        xfer(32'h0, 32, got);
        ss_down();
        check_eq("tx_word", got, tx_q.pop_front());
        check_eq("echo_wait_state", 32'(state_o), 32'h5);
        ss_up();
        xfer(echo_w, 32, unused_rx);
        ss_down();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_state"}, 32'(state_o), 32'h0);
        check_eq({tag, "_sdo"}, 32'(sdo), 32'h0);
        check_eq({tag, "_count"}, 32'(sample_count), 32'h0);
        check_eq({tag, "_rd_data"}, 32'(rd_data), 32'h0);
        check_eq({tag, "_flags"}, {28'h0, input_ready, transmit_ready, data_confirmed, error}, 32'h0);
    endtask

    initial begin
        logic [31:0] rx;

        wait_clk(4);
        check_reset_outputs("por");
        reset = 1'b1;
        wait_clk(4);

        // Mid-capture reset: two words land, then reset drops for one cycle.
        ss_up();
        xfer(32'h155, 32, rx);
        xfer(32'h0AA, 32, rx);
        check_eq("pre_reset_count", 32'(sample_count), 32'h2);
        reset = 1'b0;
        wait_clk(1);
        reset = 1'b1;
        check_reset_outputs("mid_reset");
        ss_down();

        // Single-frame capture; a stray result_valid during capture is ignored.
        ss_up();
        check_eq("capture_state", 32'(state_o), 32'h1);
        send_sample(test_words[0]);
        send_sample(test_words[1]);
        pulse_result(32'hDEAD_BEEF);
        check_eq("rv_ignored_state", 32'(state_o), 32'h1);
        send_sample(test_words[2]);
        send_sample(test_words[3]);
        ss_down();
        check_eq("full_count", 32'(sample_count), 32'h4);
        check_eq("input_ready", 32'(input_ready), 32'h1);
        check_eq("process_state", 32'(state_o), 32'h2);
        check_buffer("frame1");

        // Send and matching echo.
        latched_exp = 32'h0000_1111;
        pulse_result(latched_exp);
        check_eq("tx_wait_state", 32'(state_o), 32'h3);
        check_eq("transmit_ready", 32'(transmit_ready), 32'h1);
        transmit(32'h0000_1111);
        check_eq("done_state", 32'(state_o), 32'h8);
        check_eq("data_confirmed", 32'(data_confirmed), 32'h1);

        // Multi-frame capture with an aborted 17-bit partial word.
        ss_up();
        check_eq("recapture_state", 32'(state_o), 32'h1);
        check_eq("recapture_count", 32'(sample_count), 32'h0);
        check_eq("confirmed_clear", 32'(data_confirmed), 32'h0);
        send_sample(test_words[0]);
        send_sample(test_words[1]);
        ss_down();
        ss_up();
        xfer(32'hFFFF_FFFF, 17, rx);
        ss_down();
        check_eq("partial_count", 32'(sample_count), 32'h2);
        ss_up();
        send_sample(test_words[2]);
        send_sample(test_words[3]);
        ss_down();
        check_eq("mf_count", 32'(sample_count), 32'h4);
        check_eq("mf_state", 32'(state_o), 32'h2);
        check_buffer("multi");

        // Echo mismatches until retries run out.
        pulse_result(latched_exp);
        for (int t = 0; t < MAX_RETRY + 1; t++) begin
            transmit(32'h0);
            if (t < MAX_RETRY) check_eq($sformatf("retry%0d_state", t), 32'(state_o), 32'h3);
        end
        check_eq("err_state", 32'(state_o), 32'h9);
        check_eq("error_flag", 32'(error), 32'h1);

        // Abort mid-SEND costs no retry: two mismatches then a match still succeed.
        ss_up();
        for (int i = 0; i < DEPTH; i++) send_sample(test_words[DEPTH-1-i]);
        ss_down();
        check_buffer("rev");
        latched_exp = 32'hA5C3_0F96;
        pulse_result(latched_exp);
        check_eq("sdo_idle_tx_wait", 32'(sdo), 32'h0);
        ss_up();
        xfer(32'h0, 10, rx);
        ss_down();
        check_eq("abort_bits", {22'h0, rx[9:0]}, {22'h0, latched_exp[31:22]});
        check_eq("abort_state", 32'(state_o), 32'h3);
        transmit(~latched_exp);
        check_eq("abort_retry1_state", 32'(state_o), 32'h3);
        transmit(32'h0);
        check_eq("abort_retry2_state", 32'(state_o), 32'h3);
        transmit(latched_exp);
        check_eq("abort_done_state", 32'(state_o), 32'h8);
        check_eq("abort_confirmed", 32'(data_confirmed), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
